open_log_ctrl: RTL and testbench

OPEN_LOG_CTRL -- requirements
Module: open_log_ctrl

---
 rtl/open_log_ctrl.sv | 157 +++++++++++++++
 tb/tb_open_log_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/open_log_ctrl.sv
// open_log_ctrl: records lock-opening attempts as {user, granted, ts} into a 9-slot
// external register memory and serves single-slot read-backs with a fixed 3-cycle latency.
// Build option: define OPEN_LOG_OVERWRITE_EN to make the log circular, so that new events
// overwrite the oldest record once all 9 slots are used. Without it, events stall while full.
module open_log_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [3:0]  evt_user,
    input  logic        evt_granted,
    input  logic        tick,
    input  logic        rd_req,
    output logic        rd_ready,
    input  logic [3:0]  rd_slot,
    output logic        rd_valid,
    output logic [16:0] rd_data,
    output logic [8:0]  mem_idx,
    output logic        mem_wr,
    output logic        mem_enable,
    output logic [16:0] mem_wdata,
    input  logic [16:0] mem_rdata,
    output logic [3:0]  count,
    output logic        full
);

    localparam logic [3:0] NumSlots = 4'd9;

    typedef enum logic [1:0] {StIdle, StWrite, StRdAddr, StRdCap} state_e;

    state_e      state_q, state_d;
    logic [11:0] ts_q;
    logic [8:0]  wptr_q;
    logic [3:0]  count_q;
    logic [16:0] rec_q;
    logic [3:0]  slot_q;
    logic        rd_valid_q;
    logic [16:0] rd_data_q;
    logic        evt_acc;
    logic        rd_acc;
    logic        slot_ok;
    logic        can_accept;

    assign full     = (count_q == NumSlots);
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign slot_ok  = (slot_q < NumSlots);
    assign evt_acc  = evt_valid & evt_ready;
    assign rd_acc   = rd_req & rd_ready;

`ifdef OPEN_LOG_OVERWRITE_EN
    assign can_accept = 1'b1;
`else
    // A full log holds off new events until reset instead of dropping them.
    assign can_accept = ~full;
`endif

    // Handshakes and next-state selection; events take priority over reads.
    always_comb begin
        state_d   = state_q;
        evt_ready = 1'b0;
        rd_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                evt_ready = ~reset & can_accept;
                rd_ready  = ~reset & ~evt_valid;
                if (evt_valid && evt_ready) begin
                    state_d = StWrite;
                end else if (rd_req && rd_ready) begin
                    state_d = StRdAddr;
                end
            end
            StWrite:  state_d = StIdle;
            StRdAddr: state_d = StRdCap;
            StRdCap:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Memory port drive, decoded purely from the current state.
    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_idx    = '0;
        mem_wdata  = '0;
        unique case (state_q)
            StWrite: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_idx    = wptr_q;
                mem_wdata  = rec_q;
            end
            StRdAddr: begin
                // Out-of-range slots skip the access but keep the same timing.
                if (slot_ok) begin
                    mem_enable = 1'b1;
                    mem_idx    = 9'b1 << slot_q;
                end
            end
            default: ;
        endcase
    end

    // State register and free-running timestamp; ts advances in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 12'(tick);
        end
    end

    // Capture the record and the read slot at their acceptance cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q  <= '0;
            slot_q <= '0;
        end else begin
            if (evt_acc) begin
                rec_q <= {evt_user, evt_granted, ts_q};
            end
            if (rd_acc) begin
                slot_q <= rd_slot;
            end
        end
    end

    // Write pointer rotation and saturating record count, updated as WRITE completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= 9'b000000001;
            count_q <= '0;
        end else if (state_q == StWrite) begin
            wptr_q <= {wptr_q[7:0], wptr_q[8]};
            if (!full) begin
                count_q <= count_q + 4'd1;
            end
        end
    end

    // Read-back capture and one-cycle rd_valid pulse after RD_CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= (state_q == StRdCap);
            if (state_q == StRdCap) begin
                rd_data_q <= slot_ok ? mem_rdata : 17'd0;
            end
        end
    end

endmodule

// File: tb/tb_open_log_ctrl.sv
// Scoreboard bench for open_log_ctrl: a reference log model predicts every memory write,
// read access and read-back; a negedge monitor compares whatever the DUT presents.
module tb_open_log_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [3:0]  evt_user = '0;
    logic        evt_granted = 1'b0;
    logic        tick = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_ready;
    logic [3:0]  rd_slot = '0;
    logic        rd_valid;
    logic [16:0] rd_data;
    logic [8:0]  mem_idx;
    logic        mem_wr;
    logic        mem_enable;
    logic [16:0] mem_wdata;
    logic [16:0] mem_rdata = '0;
    logic [3:0]  count;
    logic        full;

    open_log_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_user    (evt_user),
        .evt_granted (evt_granted),
        .tick        (tick),
        .rd_req      (rd_req),
        .rd_ready    (rd_ready),
        .rd_slot     (rd_slot),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_idx     (mem_idx),
        .mem_wr      (mem_wr),
        .mem_enable  (mem_enable),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit started = 1'b0;
    int tick_mode = 0;  // 0 random, 1 always, 2 never

    typedef struct {
        logic [16:0] data;
        int          acc;
    } rd_exp_t;

    logic [25:0] wq[$];   // {idx, data}
    logic [8:0]  raq[$];
    rd_exp_t     rq[$];

    // Reference model state
    logic [16:0] ref_log[9];
    logic [16:0] env_mem[9];
    logic [11:0] ts_m = '0;
    int          wslot_m = 0;
    int          cnt_m = 0;
    int          pend_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [8:0] oh(input int s);
        logic [8:0] one = 9'd1;
        return one << s;
    endfunction

    initial begin
        for (int i = 0; i < 9; i++) begin
            env_mem[i] = (i == 2) ? 17'h1ABCD : 17'(i * 4660 + 7);
            ref_log[i] = env_mem[i];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register memory environment: one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (mem_enable && mem_idx[i]) begin
                if (mem_wr) env_mem[i] <= mem_wdata;
                else mem_rdata <= env_mem[i];
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        tick = (tick_mode == 0) ? 1'($urandom_range(0, 1)) : (tick_mode == 1);
    end

    // Monitor + reference model, evaluated on the falling edge.
    logic [25:0] we;
    rd_exp_t     re;
    always @(negedge clk) begin
        if (started) begin
            if (mem_wr) begin
                if (wq.size() == 0) chk("unexpected write", 1, 0);
                else begin
                    we = wq.pop_front();
                    chk("write idx", 32'(mem_idx), 32'(we[25:17]));
                    chk("write data", 32'(mem_wdata), 32'(we[16:0]));
                    chk("write enable", 32'(mem_enable), 1);
                end
            end else if (mem_enable) begin
                if (raq.size() == 0) chk("unexpected read access", 1, 0);
                else chk("read idx", 32'(mem_idx), 32'(raq.pop_front()));
            end else begin
                chk("idle mem outputs", 32'({mem_idx, mem_wdata}), 0);
            end
            if (rd_valid) begin
                if (rq.size() == 0) chk("unexpected rd_valid", 1, 0);
                else begin
                    re = rq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(re.data));
                    chk("read latency", 32'(cyc - re.acc), 3);
                end
            end
            chk("count", 32'(count), 32'(cnt_m));
            chk("full", 32'(full), 32'(cnt_m == 9));
            if (reset) begin
                chk("evt_ready in reset", 32'(evt_ready), 0);
                chk("rd_ready in reset", 32'(rd_ready), 0);
            end
`ifndef OPEN_LOG_OVERWRITE_EN
            if (!reset && cnt_m == 9 && pend_m == 0) chk("evt_ready while full", 32'(evt_ready), 0);
`endif
            if (evt_valid && rd_ready) chk("rd_ready with evt_valid", 1, 0);
        end
        if (pend_m != 0) begin
            if (cnt_m < 9) cnt_m++;
            pend_m = 0;
        end
        if (evt_valid && evt_ready) begin
            ref_log[wslot_m] = {evt_user, evt_granted, ts_m};
            wq.push_back({oh(wslot_m), evt_user, evt_granted, ts_m});
            wslot_m = (wslot_m + 1) % 9;
            pend_m = 1;
        end
        if (rd_req && rd_ready) begin
            re.data = (rd_slot < 9) ? ref_log[rd_slot] : 17'd0;
            re.acc  = cyc;
            rq.push_back(re);
            if (rd_slot < 9) raq.push_back(oh(int'(rd_slot)));
        end
        if (reset) begin
            ts_m = '0;
            cnt_m = 0;
            pend_m = 0;
            wslot_m = 0;
            wq.delete();
            raq.delete();
            rq.delete();
        end else if (tick) begin
            ts_m = ts_m + 12'd1;
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    task automatic send_evt(input logic [3:0] u, input logic g);
        int n = 0;
        bit done = 1'b0;
        evt_valid = 1'b1;
        evt_user = u;
        evt_granted = g;
        while (!done) begin
            @(negedge clk);
            if (evt_ready) done = 1'b1;
            else if (++n > 100) begin
                chk("evt accept timeout", 0, 1);
                done = 1'b1;
            end
            idle(1);
        end
        evt_valid = 1'b0;
    endtask

    task automatic send_rd(input logic [3:0] s);
        int n = 0;
        bit done = 1'b0;
        rd_req = 1'b1;
        rd_slot = s;
        while (!done) begin
            @(negedge clk);
            if (rd_ready) done = 1'b1;
            else if (++n > 100) begin
                chk("rd accept timeout", 0, 1);
                done = 1'b1;
            end
            idle(1);
        end
        rd_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem"}, 32'({mem_enable, mem_wr, mem_idx}), 0);
        chk({tag, " wdata"}, 32'(mem_wdata), 0);
        chk({tag, " rd"}, 32'({rd_valid, rd_data}), 0);
        chk({tag, " count/full"}, 32'({count, full}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev_cyc;
        int n;
        int bad;
        tick_mode = 2;
        idle(1);
        do_reset(3);
        chk_reset_outputs("post-reset");
        started = 1'b1;

        // Reads from the freshly reset log: slot 2 in range, slot 11 out of range.
        send_rd(4'd2);
        idle(4);
        send_rd(4'd11);
        idle(4);

        // Three ticks, then the first event must carry ts=3.
        do_reset(1);
        @(negedge clk);
        tick_mode = 1;
        repeat (3) @(negedge clk);
        tick_mode = 2;
        idle(1);
        send_evt(4'h5, 1'b1);
        idle(2);
        chk("first record count", 32'(count), 1);

        // Fill the log.
        tick_mode = 0;
        for (int i = 0; i < 8; i++) send_evt(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        idle(2);
        chk("full count", 32'({count, full}), 32'({4'd9, 1'b1}));

`ifdef OPEN_LOG_OVERWRITE_EN
        send_evt(4'hA, 1'b0);
        idle(2);
        chk("overwrite count", 32'({count, full}), 32'({4'd9, 1'b1}));
`else
        evt_valid = 1'b1;
        evt_user = 4'hA;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (evt_ready || mem_wr) bad++;
            idle(1);
        end
        evt_valid = 1'b0;
        chk("stall while full", 32'(bad), 0);
`endif

        // Read back every slot plus a few out-of-range ones.
        for (int s = 0; s < 12; s++) send_rd(4'(s));
        idle(4);

        // Simultaneous event and read: the event wins, read follows on the next IDLE.
        do_reset(1);
        evt_valid = 1'b1;
        evt_user = 4'h3;
        evt_granted = 1'b0;
        rd_req = 1'b1;
        rd_slot = 4'd0;
        @(negedge clk);
        chk("sim evt_ready", 32'(evt_ready), 1);
        chk("sim rd_ready", 32'(rd_ready), 0);
        ev_cyc = cyc;
        idle(1);
        evt_valid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (rd_ready || ++n > 20) break;
            idle(1);
        end
        chk("sim read accept cycle", 32'(cyc - ev_cyc), 2);
        idle(1);
        rd_req = 1'b0;
        idle(4);

        // Random mix of events and reads.
        for (int i = 0; i < 60; i++) begin
`ifdef OPEN_LOG_OVERWRITE_EN
            if ($urandom_range(0, 1) == 1)
`else
            if ($urandom_range(0, 1) == 1 && (cnt_m + pend_m) < 9)
`endif
                send_evt(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else send_rd(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        // Timestamp wrap: 4096 ticks from zero brings ts back to 0.
        tick_mode = 2;
        do_reset(2);
        @(negedge clk);
        tick_mode = 1;
        repeat (4096) @(negedge clk);
        tick_mode = 2;
        idle(1);
        send_evt(4'hC, 1'b1);
        send_rd(4'd0);
        idle(4);

        // Reset while in RD_ADDR aborts the read.
        tick_mode = 0;
        send_evt(4'h7, 1'b1);
        send_rd(4'd0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk_reset_outputs("abort");
        idle(6);

        chk("pending writes", 32'(wq.size()), 0);
        chk("pending reads", 32'(rq.size()), 0);
        chk("pending read accesses", 32'(raq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
